// File: rtl/prog_loader.sv
// Serial program loader: receives 8N1 bytes into a 16 x 8 instruction RAM while
// holding the CPU in reset; the CPU fetches {op, im} combinationally by pc.
module prog_loader #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       load_req,
    input  logic [3:0] pc,
    output logic [3:0] op,
    output logic [3:0] im,
    output logic       cpu_rst,
    output logic       busy,
    output logic       err,
    output logic [3:0] wr_addr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic             rxd_p0;
    logic             rxd_p1;
    logic             rxd_p2;
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             stop_tick;
    logic [7:0]       ram [16];

    // rxd_p0/rxd_p1 form the synchronizer; rxd_p2 only serves falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
            rxd_p2 <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxd_p1 <= rxd_p0;
            rxd_p2 <= rxd_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    if (!rxd_p1 && rxd_p2) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt  <= '0;
                        rx_state <= rxd_p1 ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        rx_shift <= {rxd_p1, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // The byte is consumed on the very edge its stop bit is sampled
    assign stop_tick = (rx_state == RX_STOP) && (bit_cnt == BIT_LAST);

    // load_req has priority over a byte finishing in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                ram[i] <= 8'h00;
            end
            busy    <= 1'b0;
            err     <= 1'b0;
            wr_addr <= 4'd0;
        end else if (load_req) begin
            busy    <= 1'b1;
            err     <= 1'b0;
            wr_addr <= 4'd0;
        end else if (busy && stop_tick) begin
            if (rxd_p1) begin
                ram[wr_addr] <= rx_shift;
                wr_addr      <= wr_addr + 4'd1;
                if (wr_addr == 4'hF) begin
                    busy <= 1'b0;
                end
            end else begin
                err <= 1'b1;
            end
        end
    end

    assign op      = ram[pc][7:4];
    assign im      = ram[pc][3:0];
    assign cpu_rst = rst | busy;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a byte-level model of the loader is checked
// against the DUT every falling clock edge, plus literal spot checks.
module tb_prog_loader;

    localparam int C   = 8;
    localparam int H   = C / 2;
    localparam int LAT = 2 + H + 9 * C;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic       load_req;
    logic [3:0] pc;
    logic [3:0] op;
    logic [3:0] im;
    logic       cpu_rst;
    logic       busy;
    logic       err;
    logic [3:0] wr_addr;

    prog_loader #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .load_req (load_req),
        .pc       (pc),
        .op       (op),
        .im       (im),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .err      (err),
        .wr_addr  (wr_addr)
    );

    int         total = 0;
    int         bad   = 0;
    bit         chk_en = 0;
    logic [7:0] model_ram [16];
    bit         model_busy = 0;
    bit         model_err  = 0;
    int         model_addr = 0;
    logic [7:0] prog [16] = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
                              8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("op", int'(op), int'(model_ram[pc][7:4]));
            check("im", int'(im), int'(model_ram[pc][3:0]));
            check("busy", int'(busy), int'(model_busy));
            check("err", int'(err), int'(model_err));
            check("wr_addr", int'(wr_addr), model_addr);
            check("cpu_rst", int'(cpu_rst), int'(rst | model_busy));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        wait_cycles(C);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model_ram[i] = 8'h00;
        model_busy = 0;
        model_err  = 0;
        model_addr = 0;
    endtask

    task automatic pulse_load();
        chk_en   = 0;
        load_req = 1'b1;
        wait_cycles(1);
        load_req   = 1'b0;
        model_busy = 1;
        model_err  = 0;
        model_addr = 0;
        chk_en     = 1;
    endtask

    // Sends one 8N1 frame; the model absorbs the byte once the line is idle again.
    task automatic send_byte(input logic [7:0] b, input logic stop, input bit timed);
        logic [3:0] a0;
        int         n;
        bit         seen;
        chk_en = 0;
        a0     = wr_addr;
        n      = 0;
        seen   = 0;
        fork
            begin
                drive_bit(1'b0);
                for (int i = 0; i < 8; i++) drive_bit(b[i]);
                drive_bit(stop);
                rxd = 1'b1;
            end
            begin
                if (timed) begin
                    while (!seen && n < 120) begin
                        @(posedge clk);
                        #1;
                        n++;
                        if (wr_addr != a0) seen = 1;
                    end
                    total++;
                    if (!seen || n < LAT - 1 || n > LAT + 1) begin
                        bad++;
                        $display("FAIL write_latency: got %0d cycles expected %0d+-1", n, LAT);
                    end
                end
            end
        join
        wait_cycles(3);
        if (model_busy) begin
            if (stop) begin
                model_ram[model_addr] = b;
                if (model_addr == 15) model_busy = 0;
                model_addr = (model_addr + 1) % 16;
            end else begin
                model_err = 1;
            end
        end
        chk_en = 1;
    endtask

    initial begin
        rst      = 1'b0;
        rxd      = 1'b1;
        load_req = 1'b0;
        pc       = 4'd0;
        model_clear();

        // reset
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            pc = 4'(i);
            #1;
            check("rst_op", int'(op), 0);
            check("rst_im", int'(im), 0);
        end
        check("rst_cpu_rst", int'(cpu_rst), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        chk_en = 1;
        wait_cycles(2);
        rst = 1'b0;
        #1;
        check("post_rst_cpu_rst", int'(cpu_rst), 0);
        wait_cycles(3);

        // full load
        pulse_load();
        check("load_busy", int'(busy), 1);
        check("load_cpu_rst", int'(cpu_rst), 1);
        for (int i = 0; i < 16; i++) send_byte(prog[i], 1'b1, i == 0);
        check("full_busy", int'(busy), 0);
        check("full_cpu_rst", int'(cpu_rst), 0);
        check("full_wr_addr", int'(wr_addr), 0);
        pc = 4'd0;
        #1;
        check("full_op0", int'(op), 4'b1011);
        check("full_im0", int'(im), 4'b0111);
        pc = 4'd15;
        #1;
        check("full_op15", int'(op), 4'b1111);
        check("full_im15", int'(im), 4'b1111);
        for (int i = 0; i < 16; i++) begin
            pc = 4'(i);
            #1;
            check("full_ram", int'({op, im}), int'(prog[i]));
        end
        wait_cycles(2);

        // traffic while idle is ignored
        send_byte(8'h12, 1'b1, 0);
        pc = 4'd0;
        #1;
        check("idle_ram0", int'({op, im}), 8'hB7);
        check("idle_err", int'(err), 0);
        check("idle_busy", int'(busy), 0);
        wait_cycles(2);

        // framing error
        pulse_load();
        send_byte(8'h11, 1'b1, 0);
        send_byte(8'h22, 1'b1, 0);
        send_byte(8'h55, 1'b0, 0);
        check("ferr_err", int'(err), 1);
        check("ferr_wr_addr", int'(wr_addr), 2);
        send_byte(8'hA5, 1'b1, 0);
        pc = 4'd2;
        #1;
        check("ferr_ram2", int'({op, im}), 8'hA5);
        check("ferr_err_sticky", int'(err), 1);
        check("ferr_wr_addr3", int'(wr_addr), 3);
        wait_cycles(1);
        pulse_load();
        check("ferr_clear", int'(err), 0);

        // glitches while loading
        rxd = 1'b0;
        wait_cycles(2);
        rxd = 1'b1;
        wait_cycles(100);
        check("glitch2_wr_addr", int'(wr_addr), 0);
        rxd = 1'b0;
        wait_cycles(4);
        rxd = 1'b1;
        wait_cycles(100);
        check("glitch4_wr_addr", int'(wr_addr), 0);
        check("glitch_err", int'(err), 0);

        // reset in the middle of a byte at wr_addr 7
        for (int i = 0; i < 7; i++) send_byte(8'hC0 + 8'(i), 1'b1, 0);
        check("abort_wr_addr7", int'(wr_addr), 7);
        rxd = 1'b0;
        wait_cycles(30);
        chk_en = 0;
        #2;
        rst = 1'b1;
        rxd = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_cpu_rst", int'(cpu_rst), 1);
        check("abort_wr_addr", int'(wr_addr), 0);
        for (int i = 0; i < 16; i++) begin
            pc = 4'(i);
            #1;
            check("abort_ram", int'({op, im}), 0);
        end
        model_clear();
        chk_en = 1;
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(3);
        check("abort_cpu_rst_low", int'(cpu_rst), 0);

        // restart at wr_addr 5
        pulse_load();
        for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1'b1, 0);
        check("restart_wr_addr5", int'(wr_addr), 5);
        pulse_load();
        check("restart_wr_addr0", int'(wr_addr), 0);
        send_byte(8'h3C, 1'b1, 0);
        pc = 4'd0;
        #1;
        check("restart_op0", int'(op), 4'h3);
        check("restart_im0", int'(im), 4'hC);
        check("restart_wr_addr1", int'(wr_addr), 1);
        wait_cycles(2);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
